// File: rtl/fifo_mem_core_if.sv
// Handshake and status bundle between the write-control stage, the FIFO
// storage core and the read side. Signal names are given from the core's
// point of view (i_ into the core, o_ out of it).
interface fifo_mem_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  i_wen_ctrl;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_ren;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rvalid;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    // Storage core side.
    modport slave (
        input  i_wen_ctrl,
        input  i_wdata,
        input  i_ren,
        output o_rdata,
        output o_rvalid,
        output o_full,
        output o_empty,
        output o_almost_full,
        output o_count,
        output o_overflow,
        output o_underflow
    );

    // Write-control / reader side.
    modport master (
        output i_wen_ctrl,
        output i_wdata,
        output i_ren,
        input  o_rdata,
        input  o_rvalid,
        input  o_full,
        input  o_empty,
        input  o_almost_full,
        input  o_count,
        input  o_overflow,
        input  o_underflow
    );
endinterface

// File: rtl/fifo_mem_core.sv
// Single-clock FIFO storage stage: register array, wrap-bit pointers,
// occupancy and status flags. Flags are derived only from the registered
// pointers, so no input reaches a flag combinationally. Writes arriving while
// full are dropped with an overflow pulse; reads while empty are ignored with
// an underflow pulse.
module fifo_mem_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 14
) (
    input  logic            i_clk,
    input  logic            i_rest,
    fifo_mem_core_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LP_AFULL = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_afull;
    logic                  w_write_ok;
    logic                  w_read_ok;

    assign w_waddr = r_wptr[ADDR_WIDTH-1:0];
    assign w_raddr = r_rptr[ADDR_WIDTH-1:0];

    // Same slot with opposite wrap bits means the writer has lapped the reader.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_waddr == w_raddr) && (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);
    assign w_afull = (w_count >= LP_AFULL);

    // Acceptance uses pre-edge flags: a full FIFO still drops a write even
    // when a read frees a slot in the same cycle, and an empty FIFO never
    // forwards a same-cycle write to the read port.
    assign w_write_ok = bus.i_wen_ctrl & ~w_full;
    assign w_read_ok  = bus.i_ren & ~w_empty;

    // Pointer advance on accepted transfers; reset discards all contents.
    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_write_ok) r_wptr <= r_wptr + 1'b1;
            if (w_read_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage array write port; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (!i_rest && w_write_ok) r_mem[w_waddr] <= bus.i_wdata;
    end

    // Registered read port and one-cycle status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_read_ok) r_rdata <= r_mem[w_raddr];
            r_rvalid    <= w_read_ok;
            r_overflow  <= bus.i_wen_ctrl & w_full;
            r_underflow <= bus.i_ren & w_empty;
        end
    end

    assign bus.o_rdata       = r_rdata;
    assign bus.o_rvalid      = r_rvalid;
    assign bus.o_full        = w_full;
    assign bus.o_empty       = w_empty;
    assign bus.o_almost_full = w_afull;
    assign bus.o_count       = w_count;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_underflow   = r_underflow;
endmodule

// File: doc/fifo_mem_core.md
Name: fifo_mem_core

Overview:
- Synchronous single-clock FIFO storage stage: dual-port register array, write/read pointers, occupancy counter and status flags.
- Sits directly downstream of the write-control stage. It consumes the registered write-enable (i_wen_ctrl) and returns o_full, which the write-control stage samples.
- Because the write-enable arrives one cycle after full is sampled, the block provides an almost-full flag and drops writes that arrive while full, reporting each dropped write with an overflow pulse.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address bits; depth DEPTH = 2**ADDR_WIDTH (16 by default).
- AFULL_LEVEL, 14, o_almost_full asserts when occupancy >= AFULL_LEVEL; legal range 1..DEPTH.

Ports:
- i_clk  input  1  sole clock; all logic on its rising edge.
- i_rest  input  1  synchronous active-high reset.
- i_wen_ctrl  input  1  write strobe from write-control stage; 1 = write i_wdata this cycle.
- i_wdata  input  DATA_WIDTH  write data, qualified by i_wen_ctrl.
- i_ren  input  1  read request.
- o_rdata  output  DATA_WIDTH  registered read data, valid when o_rvalid=1.
- o_rvalid  output  1  one-cycle pulse: o_rdata holds the word popped in the previous cycle.
- o_full  output  1  occupancy == DEPTH.
- o_empty  output  1  occupancy == 0.
- o_almost_full  output  1  occupancy >= AFULL_LEVEL.
- o_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- o_overflow  output  1  one-cycle pulse: a write was dropped.
- o_underflow  output  1  one-cycle pulse: a read was ignored.

Behaviour:
- Reset (i_rest=1 at clock edge): write/read pointers=0, count=0, o_empty=1, o_full=0, o_almost_full=0, o_rvalid=0, o_rdata=0, o_overflow=0, o_underflow=0. Reset wins over any simultaneous i_wen_ctrl/i_ren. The memory array is not reset.
- Reset mid-operation: contents are discarded. The first cycle after reset behaves as an empty FIFO, and old data is never returned.
- Pointers are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address the array; the MSB is a wrap bit. Pointers wrap naturally from DEPTH-1 to 0 with the wrap bit toggling.
- Flag derivation:
  - o_full when pointer addresses are equal and wrap bits differ.
  - o_empty when the pointers are fully equal.
  - o_count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - All flags and the count are registered, or derived combinationally from registered pointers only. No combinational path from any input to any flag.
- Write accept: write_ok = i_wen_ctrl & ~o_full, evaluated on pre-edge state. On accept, mem[wptr] <= i_wdata and wptr increments.
- Write drop: i_wen_ctrl=1 while o_full=1 leaves memory and pointer unchanged; o_overflow=1 for the next cycle only.
- Read accept: read_ok = i_ren & ~o_empty, evaluated on pre-edge state. On accept, o_rdata <= mem[rptr], rptr increments, and o_rvalid=1 in the next cycle. Read latency is 1 cycle.
- Read ignore: i_ren=1 while o_empty=1 leaves state unchanged; o_rvalid=0; o_underflow=1 for the next cycle.
- o_rdata holds its last value when no read is accepted.
- Simultaneous write and read:
  - Neither full nor empty: both accepted; count unchanged.
  - When full: the read is accepted and the write is dropped with an overflow pulse, because full is sampled pre-edge. Count goes to DEPTH-1.
  - When empty: the write is accepted and the read is ignored with an underflow pulse. Count goes to 1. No write-through bypass: the new word is readable from the next cycle.
- Count update per cycle: +1 for write only, -1 for read only, 0 for both or neither.
- o_almost_full gives upstream margin for the one-cycle write-control latency. The block does not gate writes on it.

Test Plan:
- Reset then idle 3 cycles -> o_empty=1, o_full=0, o_count=0, o_rvalid=0, o_rdata=0.
- Write 0x01..0x10 on consecutive cycles (16 writes) -> o_count 1..16; o_almost_full rises the cycle after the 14th write; o_full=1 after the 16th write.
- From full, pulse i_wen_ctrl with 0xAA -> o_overflow=1 for one cycle, o_count stays 16; then read 16 times -> o_rdata sequence 0x01..0x10, each with o_rvalid=1 one cycle after i_ren, and o_empty=1 after the last read.
- Wrap-around: write 10, read 10, then write 0x20..0x2F (16 words) and read them back -> order preserved across the pointer wrap, o_count peaks at 16.
- Simultaneous i_wen_ctrl=1/i_ren=1:
  - Empty -> count goes 0 to 1, o_underflow=1 for one cycle, no o_rvalid.
  - Full -> count goes 16 to 15, o_overflow=1, oldest word returned.
  - Half-full (count 8) -> count stays 8.
- Reset mid-stream at count 7 with i_wen_ctrl=1 and i_ren=1 on the reset cycle -> next cycle o_count=0, o_empty=1, o_rvalid=0; a subsequent read attempt gives o_underflow=1.
